// File: rtl/muldiv_ctrl_if.sv
// Execute-stage HI/LO unit bus.
//   master: pipeline side. It drives issue/flush, the eight op strobes and
//           rs_data/rt_data, and it observes hi/lo/busy/stall/div0.
//   slave : muldiv_ctrl side.
interface muldiv_ctrl_if #(
  parameter int DATA_W = 32
);
  logic              issue;
  logic              flush;
  logic              op_mult;
  logic              op_multu;
  logic              op_div;
  logic              op_divu;
  logic              op_mthi;
  logic              op_mtlo;
  logic              op_mfhi;
  logic              op_mflo;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;
  logic              busy;
  logic              stall;
  logic              div0;

  modport master (
    output issue, flush, op_mult, op_multu, op_div, op_divu,
           op_mthi, op_mtlo, op_mfhi, op_mflo, rs_data, rt_data,
    input  hi, lo, busy, stall, div0
  );

  modport slave (
    input  issue, flush, op_mult, op_multu, op_div, op_divu,
           op_mthi, op_mtlo, op_mfhi, op_mflo, rs_data, rt_data,
    output hi, lo, busy, stall, div0
  );
endinterface

// File: rtl/muldiv_ctrl.sv
// Multi-cycle multiply/divide sequencer that owns the HI/LO registers.
// It performs a shift-add multiply or a restoring divide, one bit per
// cycle, and then spends one FIX cycle on sign correction.
//   clk, rst : clock and synchronous active-high reset
//   bus      : muldiv_ctrl_if.slave. The inputs are issue/flush, the op
//              strobes and the operands. The outputs are hi, lo, busy,
//              stall and div0.
module muldiv_ctrl #(
  parameter int DATA_W = 32
) (
  input  logic          clk,
  input  logic          rst,
  muldiv_ctrl_if.slave  bus
);
  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  state_t state, state_nx;

  logic [2*DATA_W-1:0] acc;    // mul: {partial, multiplier}  div: {rem, quotient}
  logic [DATA_W-1:0]   opnd;   // multiplicand or divisor (absolute value)
  logic [CNT_W-1:0]    cnt;
  logic                is_div;
  logic                neg_q;  // product / quotient sign
  logic                neg_r;  // remainder sign
  logic                zdiv;
  logic [DATA_W-1:0]   hi_r, lo_r;
  logic                div0_r;

  // Strobe decode, priority mult > multu > div > divu > mthi > mtlo.
  logic accept, do_mul, do_div, do_mthi, do_mtlo, sgn, any_op, last;
  logic [DATA_W-1:0] abs_rs, abs_rt;

  always_comb begin
    accept  = bus.issue & (state == S_IDLE) & ~bus.flush;
    do_mul  = bus.op_mult | bus.op_multu;
    do_div  = ~do_mul & (bus.op_div | bus.op_divu);
    do_mthi = ~do_mul & ~do_div & bus.op_mthi;
    do_mtlo = ~do_mul & ~do_div & ~bus.op_mthi & bus.op_mtlo;
    sgn     = bus.op_mult | (~bus.op_multu & bus.op_div);
    any_op  = bus.op_mult | bus.op_multu | bus.op_div | bus.op_divu |
              bus.op_mthi | bus.op_mtlo | bus.op_mfhi | bus.op_mflo;
    abs_rs  = (sgn & bus.rs_data[DATA_W-1]) ? -bus.rs_data : bus.rs_data;
    abs_rt  = (sgn & bus.rt_data[DATA_W-1]) ? -bus.rt_data : bus.rt_data;
    last    = (cnt == CNT_W'(DATA_W - 1));
  end

  // Iteration step datapath and the sign-corrected results.
  logic [DATA_W:0]     mul_sum, mul_hi, div_shift, div_trial;
  logic                div_ok;
  logic [DATA_W-1:0]   rem_nx, quo_fix, rem_fix;
  logic [2*DATA_W-1:0] prod_fix;

  always_comb begin
    mul_sum   = {1'b0, acc[2*DATA_W-1:DATA_W]} + {1'b0, opnd};
    mul_hi    = acc[0] ? mul_sum : {1'b0, acc[2*DATA_W-1:DATA_W]};
    div_shift = {acc[2*DATA_W-1:DATA_W], acc[DATA_W-1]};
    div_trial = div_shift - {1'b0, opnd};
    div_ok    = ~div_trial[DATA_W];
    rem_nx    = div_ok ? div_trial[DATA_W-1:0] : div_shift[DATA_W-1:0];
    prod_fix  = neg_q ? -acc : acc;
    quo_fix   = neg_q ? -acc[DATA_W-1:0] : acc[DATA_W-1:0];
    rem_fix   = neg_r ? -acc[2*DATA_W-1:DATA_W] : acc[2*DATA_W-1:DATA_W];
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: begin
        if (accept && do_mul)      state_nx = S_MUL;
        else if (accept && do_div) state_nx = S_DIV;
      end
      S_MUL, S_DIV: begin
        if (bus.flush)  state_nx = S_IDLE;
        else if (last)  state_nx = S_FIX;
      end
      S_FIX:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    bus.busy  = (state != S_IDLE);
    bus.stall = bus.issue & bus.busy & any_op;
    bus.hi    = hi_r;
    bus.lo    = lo_r;
    bus.div0  = div0_r;
  end

  // Datapath and HI/LO
  always_ff @(posedge clk) begin
    if (rst) begin
      acc    <= '0;
      opnd   <= '0;
      cnt    <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      zdiv   <= 1'b0;
      hi_r   <= '0;
      lo_r   <= '0;
      div0_r <= 1'b0;
    end else begin
      div0_r <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            if (do_mul || do_div) begin
              cnt    <= '0;
              is_div <= do_div;
              neg_q  <= sgn & (bus.rs_data[DATA_W-1] ^ bus.rt_data[DATA_W-1]);
              neg_r  <= sgn & bus.rs_data[DATA_W-1];
              zdiv   <= (bus.rt_data == '0);
            end
            if (do_mul) begin
              acc  <= {{DATA_W{1'b0}}, abs_rt};
              opnd <= abs_rs;
            end else if (do_div) begin
              acc  <= {{DATA_W{1'b0}}, abs_rs};
              opnd <= abs_rt;
            end else if (do_mthi) begin
              hi_r <= bus.rs_data;
            end else if (do_mtlo) begin
              lo_r <= bus.rs_data;
            end
          end
        end
        S_MUL: begin
          acc <= {mul_hi, acc[DATA_W-1:1]};
          cnt <= cnt + 1'b1;
        end
        S_DIV: begin
          acc <= {rem_nx, acc[DATA_W-2:0], div_ok};
          cnt <= cnt + 1'b1;
        end
        S_FIX: begin
          if (!bus.flush) begin
            if (!is_div) begin
              {hi_r, lo_r} <= prod_fix;
            end else begin
              // With a zero divisor, every trial subtract succeeds. The
              // remainder therefore ends up as |rs|, and rem_fix restores rs.
              hi_r   <= rem_fix;
              lo_r   <= zdiv ? '1 : quo_fix;
              div0_r <= zdiv;
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_ctrl.sv
module tb_muldiv_ctrl;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  muldiv_ctrl_if #(.DATA_W(W)) bus ();

  muldiv_ctrl #(.DATA_W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         div0;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;

  // mask bit order: mult, multu, div, divu, mthi, mtlo, mfhi, mflo (bit0..7)
  localparam logic [7:0] M_MULT  = 8'h01, M_MULTU = 8'h02, M_DIV = 8'h04,
                         M_DIVU  = 8'h08, M_MTHI  = 8'h10, M_MTLO = 8'h20,
                         M_MFHI  = 8'h40, M_MFLO  = 8'h80;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_ops(input logic [7:0] m);
    bus.op_mult  = m[0];
    bus.op_multu = m[1];
    bus.op_div   = m[2];
    bus.op_divu  = m[3];
    bus.op_mthi  = m[4];
    bus.op_mtlo  = m[5];
    bus.op_mfhi  = m[6];
    bus.op_mflo  = m[7];
  endtask

  // Drives an instruction for one edge. It returns 1 ns after that edge.
  task automatic issue_op(input logic [7:0] m, input logic [W-1:0] rs, input logic [W-1:0] rt);
    bus.issue   = 1'b1;
    set_ops(m);
    bus.rs_data = rs;
    bus.rt_data = rt;
    @(posedge clk);
    #1;
    bus.issue = 1'b0;
    set_ops(8'h00);
  endtask

  // Counts the busy cycles, with a bound, starting in the cycle after the accept.
  task automatic wait_idle(output int n);
    n = 0;
    @(negedge clk);
    while (bus.busy === 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  // The scoreboard monitor compares every falling edge of busy against the queue.
  logic busy_q = 1'b0;
  always @(negedge clk) begin
    if (busy_q && bus.busy === 1'b0) begin
      exp_t e;
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_unexpected: got completion expected none");
      end else begin
        e = sb.pop_front();
        check("sb_hi",   {32'h0, bus.hi},   {32'h0, e.hi});
        check("sb_lo",   {32'h0, bus.lo},   {32'h0, e.lo});
        check("sb_div0", {63'h0, bus.div0}, {63'h0, e.div0});
      end
    end
    busy_q = (bus.busy === 1'b1);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0]   m;
    logic [W-1:0] rs, rt, hi, lo;
    logic         d0;
  } vec_t;

  vec_t vecs[9];
  int n;

  initial begin
    bus.issue = 1'b0; bus.flush = 1'b0; set_ops(8'h00);
    bus.rs_data = '0; bus.rt_data = '0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_hi",   {32'h0, bus.hi}, 64'h0);
    check("rst_lo",   {32'h0, bus.lo}, 64'h0);
    check("rst_busy", {63'h0, bus.busy}, 64'h0);
    check("rst_div0", {63'h0, bus.div0}, 64'h0);
    rst = 1'b0;

    // Preload hi/lo, then reset during cycle 10 of a multiply.
    issue_op(M_MTHI, 32'h5555_0000, 0);
    issue_op(M_MTLO, 32'h0000_AAAA, 0);
    issue_op(M_MULT, 32'd9, 32'd9);
    repeat (9) @(posedge clk);
    #1;
    sb.push_back('{hi: 0, lo: 0, div0: 1'b0});
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rstmid_busy", {63'h0, bus.busy}, 64'h0);
    issue_op(M_MTHI, 32'h0000_1234, 0);
    @(negedge clk);
    check("mthi_hi", {32'h0, bus.hi}, 64'h0000_1234);
    check("mthi_lo", {32'h0, bus.lo}, 64'h0);

    // Hand-computed results.
    vecs[0] = '{M_MULT,  32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
    vecs[1] = '{M_MULTU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
    vecs[2] = '{M_DIV,   32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
    vecs[3] = '{M_DIVU,  32'd100,        32'd7,         32'd2,         32'd14,        1'b0};
    vecs[4] = '{M_DIVU,  32'hDEAD_BEEF,  32'd0,         32'hDEAD_BEEF, 32'hFFFF_FFFF, 1'b1};
    vecs[5] = '{M_DIV,   32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1};
    vecs[6] = '{M_DIV,   32'h8000_0000,  32'hFFFF_FFFF, 32'h0,         32'h8000_0000, 1'b0};
    vecs[7] = '{M_MULT | M_DIV | M_MTHI, 32'd3, 32'd5,  32'h0,         32'd15,        1'b0};
    vecs[8] = '{M_DIV,   32'd7,          32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0};

    foreach (vecs[i]) begin
      sb.push_back('{hi: vecs[i].hi, lo: vecs[i].lo, div0: vecs[i].d0});
      issue_op(vecs[i].m, vecs[i].rs, vecs[i].rt);
      wait_idle(n);
      check($sformatf("latency_%0d", i), 64'(n), 64'd33);
      @(negedge clk);
      check($sformatf("div0_pulse_end_%0d", i), {63'h0, bus.div0}, 64'h0);
    end

    // If both mthi and mtlo are set, only hi is written.
    issue_op(M_MTHI | M_MTLO, 32'hCAFE_0001, 0);
    @(negedge clk);
    check("mt_prio_hi", {32'h0, bus.hi}, 64'hCAFE_0001);
    check("mt_prio_lo", {32'h0, bus.lo}, 64'hFFFF_FFFD);

    // An mflo presented at E+5 stays stalled until the product is visible.
    sb.push_back('{hi: 32'h0, lo: 32'd30, div0: 1'b0});
    issue_op(M_MULT, 32'd5, 32'd6);
    repeat (4) @(posedge clk);
    #1;
    bus.issue = 1'b1;
    set_ops(M_MFLO);
    n = 0;
    @(negedge clk);
    while (bus.stall === 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
    check("stall_cycles", 64'(n), 64'd29);
    check("stall_lo", {32'h0, bus.lo}, 64'd30);
    @(posedge clk);
    #1;
    bus.issue = 1'b0;
    set_ops(8'h00);

    // A flush at E+12 aborts the op. hi/lo keep their values and div0 stays low.
    sb.push_back('{hi: 32'h0, lo: 32'd30, div0: 1'b0});
    issue_op(M_MULT, 32'd2, 32'd3);
    repeat (11) @(posedge clk);
    #1;
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    @(negedge clk);
    check("flush_busy", {63'h0, bus.busy}, 64'h0);
    repeat (3) @(negedge clk);
    check("flush_hi", {32'h0, bus.hi}, 64'h0);
    check("flush_lo", {32'h0, bus.lo}, 64'd30);

    // A flush in IDLE blocks the accept.
    bus.flush = 1'b1;
    issue_op(M_MTHI, 32'hBAD0_BAD0, 0);
    bus.flush = 1'b0;
    @(negedge clk);
    check("idle_flush_hi", {32'h0, bus.hi}, 64'h0);
    check("idle_flush_busy", {63'h0, bus.busy}, 64'h0);

    repeat (2) @(negedge clk);
    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
Multi-cycle multiply/divide sequencer owning the HI/LO registers of the CPU execute stage. Takes decoder strobes (op_mult, op_multu, op_div, op_divu, op_mthi, op_mtlo, op_mfhi, op_mflo) and operands. Runs iterative shift-add multiply or restoring divide, one bit per cycle. Raises a pipeline stall while any HI/LO-touching instruction would collide with an operation in flight.

Parameters:
DATA_W, 32, operand/HI/LO width; iteration count equals DATA_W.

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
issue  in  1  instruction in EX is valid and not being squashed
flush  in  1  abort any in-flight operation (exception/eret)
op_mult  in  1  signed multiply strobe
op_multu  in  1  unsigned multiply strobe
op_div  in  1  signed divide strobe
op_divu  in  1  unsigned divide strobe
op_mthi  in  1  write rs_data to HI
op_mtlo  in  1  write rs_data to LO
op_mfhi  in  1  read HI
op_mflo  in  1  read LO
rs_data  in  DATA_W  first operand / dividend / mt* source
rt_data  in  DATA_W  second operand / divisor
hi  out  DATA_W  HI register
lo  out  DATA_W  LO register
busy  out  1  operation in flight
stall  out  1  hold pipeline (combinational)
div0  out  1  one-cycle pulse: completed divide had zero divisor

Behaviour:
- Reset: one clock and synchronous active-high reset, per the fixed interface decision. rst high at a clk edge clears hi, lo, busy, div0 and the counter, and sets the state to IDLE, including mid-operation. rst overrides flush and issue.
- States: IDLE, MUL, DIV, FIX.
- Accept condition: issue=1, state=IDLE, flush=0.
- Strobe priority when more than one is set: mult > multu > div > divu > mthi > mtlo. mf* has no side effect.
- IDLE, accept of mult/multu/div/divu:
  - Latch operands. Signed ops store absolute values and record result signs (product sign = sign(rs) xor sign(rt); quotient sign the same; remainder sign = sign(rs)).
  - Clear the counter and go to MUL or DIV.
  - Also latch a zero-divisor flag for divides.
- IDLE, accept of mthi/mtlo: write rs_data to hi or lo at that edge. No state change.
- MUL: each cycle performs one shift-add step on a 2*DATA_W accumulator, counter+1. After DATA_W steps, go to FIX.
- DIV: each cycle performs one restoring step (shift remainder, trial subtract, set quotient bit), counter+1. After DATA_W steps, go to FIX.
- FIX:
  - Apply two's-complement sign correction.
  - Write hi/lo at the edge leaving FIX, then go to IDLE.
  - Multiply: {hi,lo} = product.
  - Divide: lo = quotient, hi = remainder.
  - Zero divisor: hi = original rs_data, lo = all ones (both signed and unsigned), and div0=1 for the cycle after that edge.
- Latency: accepted at edge E. busy=1 for cycles E+1 .. E+DATA_W+1 (MUL/DIV plus FIX). Result visible on hi/lo from edge E+DATA_W+2 onward, which is 34 cycles for DATA_W=32.
- busy is registered: 1 in MUL, DIV and FIX.
- stall = issue & busy & (any of the eight strobes). A stalled instruction is re-presented by the pipeline; it is accepted on the first cycle in IDLE.
- A mf* in the cycle hi/lo are written (FIX exit) is stalled; hi/lo therefore never present a partial value to a reader.
- flush while busy: return to IDLE next edge, hi/lo unchanged, no div0. flush in IDLE blocks accept that cycle.
- Overflow case: signed -2^31 / -1 gives lo=0x80000000, hi=0. This is the natural result of the sign correction; no trap.
- Counter width is ceil(log2(DATA_W+1)); counter wrap is never reached.

Test Plan:
- rst mid-MUL (cycle 10 of 32) -> next cycle busy=0, hi=lo=0, IDLE; then mthi 0x1234 -> hi=0x00001234.
- mult rs=7, rt=0xFFFFFFFD (-3) -> busy high cycles E+1..E+33; at E+34 hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- multu rs=rt=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001 after 34 cycles.
- div rs=0xFFFFFFF9 (-7), rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu 100/7 -> lo=14, hi=2.
- divu rs=0xDEADBEEF, rt=0 -> hi=0xDEADBEEF, lo=0xFFFFFFFF, div0 pulse exactly one cycle.
- mflo issued at E+5 of a mult -> stall=1 through E+33 and 0 at E+34, when lo holds the product. Then mult with flush at E+12 -> busy=0 next cycle, hi/lo keep the previous values.
